// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: command encodings, FSM states,
// wait-counter width and the alignment/reserved-command check.
package mem_pkg;

    typedef enum logic [1:0] {
        SB = 2'b00,
        SH = 2'b01,
        SW = 2'b10
    } store_size_e;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int WAIT_W = 4;

    // High when the access must not be performed: reserved encoding or bad alignment.
    function automatic logic access_bad(input logic       is_write,
                                        input logic [1:0] size,
                                        input logic [2:0] ltype,
                                        input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (is_write) begin
            case (size)
                SB:      bad = 1'b0;
                SH:      bad = addr_lo[0];
                SW:      bad = |addr_lo;
                default: bad = 1'b1;
            endcase
        end else begin
            case (ltype)
                LB, LBU: bad = 1'b0;
                LH, LHU: bad = addr_lo[0];
                LW:      bad = |addr_lo;
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_responder_load_gen.sv
// Combinational load lane select and sign/zero extension of a memory word.
module load_gen
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_ltype,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = '0;
        case (i_ltype)
            LB:      o_data = {{24{w_byte[7]}}, w_byte};
            LH:      o_data = {{16{w_half[15]}}, w_half};
            LW:      o_data = i_word;
            LBU:     o_data = {24'd0, w_byte};
            LHU:     o_data = {16'd0, w_half};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the EX/MEM stage: stalls the pipeline while a
// load or store runs against a word-organised memory with wait states.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_read_in,
    input  logic        data_mem_write_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [1:0]  data_men_write_command_in,
    input  logic [2:0]  load_gen_command_in,
    output logic        stall_out,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        misaligned_out,
    output logic [1:0]  dbg_state_out
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

    state_e            r_state;
    state_e            w_next_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [AW+1:0]     r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_size;
    logic [2:0]        r_ltype;
    logic              r_is_write;
    logic              r_is_read;
    logic [31:0]       r_load_data;
    logic              r_load_valid;
    logic              r_misaligned;

    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_req;
    logic              w_commit;
    logic              w_bad;
    logic [AW-1:0]     w_idx;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_load_data;
    logic [3:0]        w_be;
    logic [31:0]       w_wlane;
    logic              w_unused;

    // Upper address bits are dropped so the memory aliases across the address space.
    assign w_unused  = ^addr_in[31:AW+2];

    assign w_req     = mem_read_in | data_mem_write_in;
    assign w_commit  = (r_state == BUSY) && (r_wait_cnt == '0);
    assign w_bad     = access_bad(r_is_write, r_size, r_ltype, r_addr[1:0]);
    assign w_idx     = r_addr[AW+1:2];
    assign w_rd_word = r_mem[w_idx];

    load_gen u_load_gen (
        .i_word    (w_rd_word),
        .i_addr_lo (r_addr[1:0]),
        .i_ltype   (r_ltype),
        .o_data    (w_load_data)
    );

    always_comb begin
        w_be    = 4'b0000;
        w_wlane = r_wdata;
        case (r_size)
            SB: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wlane = {4{r_wdata[7:0]}};
            end
            SH: begin
                w_be    = 4'b0011 << r_addr[1:0];
                w_wlane = {2{r_wdata[15:0]}};
            end
            SW: begin
                w_be    = 4'b1111;
                w_wlane = r_wdata;
            end
            default: begin
                w_be    = 4'b0000;
                w_wlane = r_wdata;
            end
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        stall_out    = 1'b0;
        case (r_state)
            IDLE: begin
                stall_out = w_req;
                if (w_req) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                stall_out = 1'b1;
                if (r_wait_cnt == '0) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_wait_cnt   <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= '0;
            r_ltype      <= '0;
            r_is_write   <= 1'b0;
            r_is_read    <= 1'b0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_load_valid <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr     <= addr_in[AW+1:0];
                        r_wdata    <= store_data_in;
                        r_size     <= data_men_write_command_in;
                        r_ltype    <= load_gen_command_in;
                        r_is_write <= data_mem_write_in;
                        r_is_read  <= mem_read_in & ~data_mem_write_in;
                        r_wait_cnt <= WAIT_INIT;
                    end
                end
                BUSY: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                    end else begin
                        r_misaligned <= w_bad;
                        if (r_is_read) begin
                            r_load_valid <= 1'b1;
                            r_load_data  <= w_bad ? 32'd0 : w_load_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory has no reset; the commit is gated by the reset-cleared FSM state.
    always_ff @(posedge clk) begin
        if (w_commit && r_is_write && !w_bad) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                end
            end
        end
    end

    assign load_data_out  = r_load_data;
    assign load_valid_out = r_load_valid;
    assign misaligned_out = r_misaligned;
    assign dbg_state_out  = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed table-driven bench for data_mem_responder with WAIT_STATES = 1.
module tb_data_mem_responder;

    localparam int WAIT_STATES = 1;
    localparam int STALL_CYC   = WAIT_STATES + 2;

    logic        clk;
    logic        resetn;
    logic        mem_read_in;
    logic        data_mem_write_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic [1:0]  data_men_write_command_in;
    logic [2:0]  load_gen_command_in;
    logic        stall_out;
    logic [31:0] load_data_out;
    logic        load_valid_out;
    logic        misaligned_out;
    logic [1:0]  dbg_state_out;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [2:0]  ltype;
        logic [31:0] exp_data;
        logic        exp_valid;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_STATES (WAIT_STATES)
    ) dut (
        .clk                       (clk),
        .resetn                    (resetn),
        .mem_read_in               (mem_read_in),
        .data_mem_write_in         (data_mem_write_in),
        .addr_in                   (addr_in),
        .store_data_in             (store_data_in),
        .data_men_write_command_in (data_men_write_command_in),
        .load_gen_command_in       (load_gen_command_in),
        .stall_out                 (stall_out),
        .load_data_out             (load_data_out),
        .load_valid_out            (load_valid_out),
        .misaligned_out            (misaligned_out),
        .dbg_state_out             (dbg_state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle_inputs();
        mem_read_in               = 1'b0;
        data_mem_write_in         = 1'b0;
        addr_in                   = '0;
        store_data_in             = '0;
        data_men_write_command_in = '0;
        load_gen_command_in       = '0;
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_req(input vec_t v, input int idx);
        int cyc;
        mem_read_in               = v.rd;
        data_mem_write_in         = v.wr;
        addr_in                   = v.addr;
        store_data_in             = v.data;
        data_men_write_command_in = v.size;
        load_gen_command_in       = v.ltype;
        #1;
        cyc = 0;
        while (stall_out === 1'b1 && cyc < 20) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        check($sformatf("v%0d_stall_cycles", idx), 32'(cyc), 32'(STALL_CYC));
        check($sformatf("v%0d_valid", idx), {31'd0, load_valid_out}, {31'd0, v.exp_valid});
        check($sformatf("v%0d_misaligned", idx), {31'd0, misaligned_out}, {31'd0, v.exp_mis});
        if (v.exp_valid) begin
            check($sformatf("v%0d_load_data", idx), load_data_out, v.exp_data);
        end
        idle_inputs();
        @(negedge clk);
        #1;
        check($sformatf("v%0d_pulse_end", idx),
              {30'd0, load_valid_out, misaligned_out}, 32'd0);
    endtask

    function automatic vec_t st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                                input logic mis);
        vec_t v;
        v = '{1'b0, 1'b1, a, d, s, 3'b000, 32'd0, 1'b0, mis};
        return v;
    endfunction

    function automatic vec_t ld(input logic [31:0] a, input logic [2:0] t,
                                input logic [31:0] e, input logic mis);
        vec_t v;
        v = '{1'b1, 1'b0, a, 32'd0, 2'b00, t, e, 1'b1, mis};
        return v;
    endfunction

    initial begin
        vecs.push_back(st(32'h10, 32'hDEADBEEF, 2'b10, 1'b0));
        vecs.push_back(ld(32'h10, 3'b010, 32'hDEADBEEF, 1'b0));
        vecs.push_back(st(32'h20, 32'h00000000, 2'b10, 1'b0));
        vecs.push_back(st(32'h21, 32'h000000F0, 2'b00, 1'b0));
        vecs.push_back(ld(32'h21, 3'b000, 32'hFFFFFFF0, 1'b0));
        vecs.push_back(ld(32'h21, 3'b100, 32'h000000F0, 1'b0));
        vecs.push_back(ld(32'h20, 3'b010, 32'h0000F000, 1'b0));
        vecs.push_back(st(32'h30, 32'h00000000, 2'b10, 1'b0));
        vecs.push_back(st(32'h32, 32'h00008001, 2'b01, 1'b0));
        vecs.push_back(ld(32'h32, 3'b001, 32'hFFFF8001, 1'b0));
        vecs.push_back(ld(32'h32, 3'b101, 32'h00008001, 1'b0));
        vecs.push_back(ld(32'h33, 3'b001, 32'h00000000, 1'b1));
        vecs.push_back(st(32'h14, 32'h11223344, 2'b10, 1'b0));
        vecs.push_back(st(32'h15, 32'hCAFEF00D, 2'b10, 1'b1));
        vecs.push_back(ld(32'h14, 3'b010, 32'h11223344, 1'b0));
        vecs.push_back(st(32'h1004, 32'h12345678, 2'b10, 1'b0));
        vecs.push_back(ld(32'h4, 3'b010, 32'h12345678, 1'b0));
        vecs.push_back(st(32'h12, 32'h0000ABCD, 2'b01, 1'b0));
        vecs.push_back(ld(32'h10, 3'b010, 32'hABCDBEEF, 1'b0));
        vecs.push_back(ld(32'h13, 3'b000, 32'hFFFFFFAB, 1'b0));
        vecs.push_back(ld(32'h12, 3'b100, 32'h000000CD, 1'b0));
        vecs.push_back(ld(32'h10, 3'b101, 32'h0000BEEF, 1'b0));
        vecs.push_back(ld(32'h10, 3'b001, 32'hFFFFBEEF, 1'b0));
        vecs.push_back(st(32'h10, 32'h00000000, 2'b11, 1'b1));
        vecs.push_back(ld(32'h10, 3'b010, 32'hABCDBEEF, 1'b0));
        vecs.push_back(ld(32'h10, 3'b011, 32'h00000000, 1'b1));
        vecs.push_back(ld(32'h12, 3'b010, 32'h00000000, 1'b1));
        vecs.push_back('{1'b1, 1'b1, 32'h50, 32'h55AA55AA, 2'b10, 3'b010, 32'd0, 1'b0, 1'b0});
        vecs.push_back(ld(32'h50, 3'b010, 32'h55AA55AA, 1'b0));
        vecs.push_back(st(32'h40, 32'h00000000, 2'b10, 1'b0));

        // Clock/reset
        resetn = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        check("in_reset_state", {30'd0, dbg_state_out}, 32'd0);
        check("in_reset_stall", {31'd0, stall_out}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        check("reset_load_data", load_data_out, 32'd0);
        check("reset_flags", {29'd0, stall_out, load_valid_out, misaligned_out}, 32'd0);
        check("reset_state", {30'd0, dbg_state_out}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_req(vecs[i], i);
        end

        // Reset during BUSY of SW 0x40: the store must not commit.
        data_mem_write_in         = 1'b1;
        addr_in                   = 32'h40;
        store_data_in             = 32'hAAAAAAAA;
        data_men_write_command_in = 2'b10;
        @(negedge clk);
        #1;
        check("midrst_busy_stall", {31'd0, stall_out}, 32'd1);
        check("midrst_busy_state", {30'd0, dbg_state_out}, 32'd1);
        resetn = 1'b0;
        idle_inputs();
        #1;
        check("midrst_stall_drop", {31'd0, stall_out}, 32'd0);
        check("midrst_state_idle", {30'd0, dbg_state_out}, 32'd0);
        @(negedge clk);
        #1;
        check("midrst_no_pulse", {30'd0, load_valid_out, misaligned_out}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_after_release", {29'd0, stall_out, load_valid_out, misaligned_out}, 32'd0);
        check("midrst_data_cleared", load_data_out, 32'd0);
        run_req(ld(32'h40, 3'b010, 32'h00000000, 1'b0), 100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
